// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared states, opcode/ALU constants and per-state strobe decode for the stack-machine controller
package stack_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_JMP, S_JZ, S_MEM_RD, S_PUSH_MEM, S_POP_A, S_LD_A,
    S_POP_B, S_LD_B, S_ALU, S_UNARY, S_PUSH_RES, S_STORE, S_FAULT
  } state_t;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_NOT   = 3'b011;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NOT  = 2'b11;
  // pc_jump is the JMP-state pc_write; the FETCH pc_write/ir_write follow mem_ready outside this table
  typedef struct packed {
    logic iord, src_a, src_b, pc_src, pc_jump, pc_write_cond, mem_read, mem_write;
    logic tos, push, pop, mtos, ld_a, ld_b;
    logic [1:0] alu_op;
  } strobe_t;
  function automatic strobe_t strobes(input state_t s, input logic [1:0] aop);
    strobe_t v;
    v = '0;
    case (s)
      S_FETCH:          begin v.src_a = 1'b1; v.src_b = 1'b1; v.mem_read = 1'b1; v.alu_op = ALU_ADD; end
      S_DECODE:         v.tos = 1'b1;
      S_JMP:            begin v.pc_src = 1'b1; v.pc_jump = 1'b1; end
      S_JZ:             begin v.pc_src = 1'b1; v.pc_write_cond = 1'b1; end
      S_POP_A, S_POP_B: v.pop = 1'b1;
      S_LD_A:           v.ld_a = 1'b1;
      S_LD_B:           v.ld_b = 1'b1;
      S_ALU:            v.alu_op = aop;
      S_UNARY:          v.alu_op = ALU_NOT;
      S_PUSH_RES:       v.push = 1'b1;
      S_STORE:          begin v.iord = 1'b1; v.mem_write = 1'b1; end
      S_MEM_RD:         begin v.iord = 1'b1; v.mem_read = 1'b1; end
      S_PUSH_MEM:       begin v.mtos = 1'b1; v.push = 1'b1; end
      default:          ;
    endcase
    return v;
  endfunction
endpackage

// File: rtl/stack_mc_controller_depth.sv
// stack_depth_tracker: stack occupancy counter and DECODE legality check (stack_ok) for the stack guard
//   clk, rst (async, active-high) | push, pop: datapath strobes | opcode: IR opcode
//   depth: current occupancy | stack_ok: opcode may execute at current depth
module stack_depth_tracker
  import stack_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [2:0]         opcode,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_ok
);
  always_ff @(posedge clk or posedge rst)
    if (rst) depth <= '0;
    else if (push) depth <= depth + 1'b1;
    else if (pop) depth <= depth - 1'b1;
  assign stack_ok = opcode == OP_JMP ? 1'b1 :
                    opcode == OP_LOAD ? depth != DEPTH_W'(STACK_DEPTH) :
                    (opcode == OP_JZ || opcode == OP_STORE || opcode == OP_NOT) ? depth != '0 :
                    depth >= DEPTH_W'(2);
endmodule

// File: rtl/stack_mc_controller.sv
// stack_mc_controller: multicycle control FSM for the stack-machine datapath with memory-ready waits and optional stack guard
//   clk, rst (async, active-high) | opcode: IR opcode | mem_ready: memory completes this cycle
//   iord..ld_b, alu_op: datapath strobes | depth: stack occupancy | fault: sticky guard trap
//   STACK_GUARD_EN: when defined, adds depth tracking and the FAULT trap; otherwise depth/fault are 0
module stack_mc_controller
  import stack_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  output logic               iord,
  output logic               src_a,
  output logic               src_b,
  output logic               pc_src,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               tos,
  output logic               push,
  output logic               pop,
  output logic               mtos,
  output logic               ld_a,
  output logic               ld_b,
  output logic [1:0]         alu_op,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault
);
  state_t st, nxt;
  strobe_t o;
  logic [2:0] op_q;
  logic stack_ok;
  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:                          nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:                         nxt = !stack_ok ? S_FAULT : opcode == OP_JMP ? S_JMP :
                                              opcode == OP_JZ ? S_JZ : opcode == OP_LOAD ? S_MEM_RD : S_POP_A;
      S_JMP, S_JZ, S_PUSH_RES, S_PUSH_MEM: nxt = S_FETCH;
      S_POP_A:                          nxt = S_LD_A;
      S_LD_A:                           nxt = op_q == OP_STORE ? S_STORE : op_q == OP_NOT ? S_UNARY : S_POP_B;
      S_POP_B:                          nxt = S_LD_B;
      S_LD_B:                           nxt = S_ALU;
      S_ALU, S_UNARY:                   nxt = S_PUSH_RES;
      S_STORE:                          nxt = mem_ready ? S_FETCH : S_STORE;
      S_MEM_RD:                         nxt = mem_ready ? S_PUSH_MEM : S_MEM_RD;
      default:                          nxt = st;
    endcase
  end
  // strobes are registered from the next state; the opcode is latched in DECODE so later edits to it are ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st   <= S_FETCH;
      o    <= strobes(S_FETCH, ALU_ADD);
      op_q <= '0;
    end else begin
      st   <= nxt;
      o    <= strobes(nxt, op_q);
      op_q <= st == S_DECODE ? opcode : op_q;
    end
  assign {iord, src_a, src_b, pc_src} = {o.iord, o.src_a, o.src_b, o.pc_src};
  assign {pc_write_cond, mem_read, mem_write, tos} = {o.pc_write_cond, o.mem_read, o.mem_write, o.tos};
  assign {push, pop, mtos, ld_a, ld_b, alu_op} = {o.push, o.pop, o.mtos, o.ld_a, o.ld_b, o.alu_op};
  // FETCH write-backs complete with the memory handshake; rst masks them immediately
  assign pc_write = ~rst & (o.pc_jump | (st == S_FETCH & mem_ready));
  assign ir_write = ~rst & st == S_FETCH & mem_ready;
`ifdef STACK_GUARD_EN
  stack_depth_tracker #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) u_trk (
    .clk(clk), .rst(rst), .push(o.push), .pop(o.pop), .opcode(opcode), .depth(depth), .stack_ok(stack_ok)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) fault <= 1'b0;
    else fault <= nxt == S_FAULT;
`else
  assign stack_ok = 1'b1;
  assign depth = '0;
  assign fault = 1'b0;
`endif
endmodule

// File: doc/stack_mc_controller.md
# stack_mc_controller

Parametrised multicycle control FSM for the stack-machine datapath: fetches, decodes and sequences the 3-bit opcode set, and drives PC, IR, memory, stack and ALU control strobes. Unlike the previous generation, it waits on a memory-ready handshake instead of assuming single-cycle memory. It also tracks stack depth against a configurable limit and traps on overflow or underflow. It sits between instruction memory/IR and the stack datapath, one instance per core.

## Interface
- STACK_DEPTH, 16: hardware stack entries, ≥2.
- DEPTH_W, $clog2(STACK_DEPTH+1): depth counter width (derived, not overridden).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset rst, asynchronous, active-high.
- opcode  in  3  IR opcode field, stable from DECODE until FETCH.
- mem_ready  in  1  memory completes the current read or write this cycle.
- iord, src_a, src_b, pc_src, pc_write, pc_write_cond, mem_read, mem_write, ir_write, tos, push, pop, mtos, ld_a, ld_b  out  1 each  datapath strobes.
- alu_op  out  2  ALU function.
- depth  out  DEPTH_W  current stack occupancy.
- fault  out  1  sticky stack-guard trap.

## Operation
- Opcodes:
  - 110 JMP, 111 JZ, 100 LOAD (mem→push), 101 STORE (pop→mem), 011 NOT (unary, alu_op 11).
  - 000/001/010 are binary ALU ops with alu_op = opcode[1:0].
- States and transitions:
  - FETCH→DECODE.
  - DECODE→JMP | JZ | MEM_RD | POP_A | FAULT.
  - JMP, JZ→FETCH.
  - POP_A→LD_A.
  - LD_A→STORE (101) | UNARY (011) | POP_B.
  - POP_B→LD_B→ALU→PUSH_RES.
  - UNARY→PUSH_RES.
  - PUSH_RES→FETCH.
  - STORE→FETCH.
  - MEM_RD→PUSH_MEM→FETCH.
  - FAULT→FAULT.
- Outputs are Moore, except that pc_write and ir_write in FETCH equal mem_ready. All strobes not listed for a state are 0.
- Strobes per state:
  - FETCH: iord=0, src_a=1, src_b=1, alu_op=00, pc_src=0, mem_read=1, pc_write=ir_write=mem_ready.
  - DECODE: tos.
  - JMP: pc_src, pc_write.
  - JZ: pc_src, pc_write_cond.
  - POP_A, POP_B: pop.
  - LD_A: ld_a.
  - LD_B: ld_b.
  - ALU: alu_op=opcode[1:0].
  - UNARY: alu_op=11.
  - PUSH_RES: push.
  - STORE: iord, mem_write.
  - MEM_RD: iord, mem_read.
  - PUSH_MEM: mtos, push.
- Memory wait states:
  - FETCH, STORE and MEM_RD hold their state and strobes while mem_ready=0.
  - They advance on the first cycle with mem_ready=1.
  - The datapath captures memory read data on mem_read & mem_ready.
- Depth counter:
  - +1 on a cycle with push.
  - −1 on a cycle with pop.
  - push and pop are never asserted together.
- Guard check in DECODE. The FSM goes to FAULT instead of executing when:
  - binary op and depth<2;
  - NOT, STORE or JZ and depth<1;
  - LOAD and depth==STACK_DEPTH.
  - JMP is never checked.
- FAULT state:
  - All strobes are 0.
  - fault=1 from the cycle after DECODE.
  - depth is frozen.
  - Exit only by rst.

## Timing
- Latency with mem_ready=1 throughout:
  - JMP, JZ: 3 cycles.
  - LOAD: 4 cycles.
  - STORE: 5 cycles.
  - NOT: 6 cycles.
  - Binary op: 8 cycles.
- Each mem_ready=0 cycle in FETCH, STORE or MEM_RD adds 1 cycle.
- pc_write pulses exactly once per FETCH, in its final cycle.
- Reset (any time, including mid-instruction or in FAULT):
  - state=FETCH, depth=0, fault=0 immediately.
  - All write strobes (pc_write, ir_write, mem_write, push, pop, ld_a, ld_b) are forced 0 while rst=1.
  - Other FETCH strobes are visible during reset.
- opcode is sampled only in DECODE, LD_A and ALU; changes in other states are ignored.

## Configuration
- STACK_GUARD_EN defined:
  - depth counter, DECODE checks and FAULT state are present, as above.
- STACK_GUARD_EN undefined:
  - No counter and no FAULT state; depth and fault are tied to 0.
  - DECODE never diverts, so overflow and underflow go undetected, as in the previous generation.

## Structure
- Shared package stack_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_JMP, OP_JZ, OP_LOAD, OP_STORE, OP_NOT);
  - ALU op constants (ALU_ADD=00, ALU_NOT=11).
- Sub-module stack_depth_tracker contains the depth counter and the DECODE legality check (stack_ok from opcode and depth). It is instantiated only under STACK_GUARD_EN.

## Test plan
- LOAD, LOAD, ADD (000), mem_ready=1:
  - depth 0→1→2→1 over 16 cycles.
  - alu_op=00 in ALU cycle 7 of ADD.
  - Single push in its cycle 8.
- Reset, then ADD at depth 0:
  - FAULT entered cycle 3, fault=1 and held.
  - No pop ever asserted.
  - rst clears fault and depth.
- STACK_DEPTH=4, five LOADs:
  - First four complete with depth=4.
  - Fifth goes to FAULT, depth stays 4.
  - With macro undefined, fifth completes and fault=0.
- mem_ready=0 for 3 cycles in FETCH:
  - FETCH lasts 4 cycles.
  - pc_write and ir_write high only in cycle 4.
  - mem_read high all 4 cycles.
- JZ at depth 1: cycle 3 has pc_write_cond=1, pc_src=1, pc_write=0; FETCH in cycle 4.
- rst asserted asynchronously during LD_B of SUB (001):
  - state=FETCH and depth=0 without a clock edge.
  - Next instruction fetched normally after release.
